decrypt: RTL
============

# decrypt

Sequential Paillier decryption stage, directly downstream of `encrypt`. It takes a `2*N_WIDTH`-bit ciphertext plus the private key (`lambda`, `mu`) and modulus `n`, and recovers the plaintext as m = L(c^lambda mod n²)·mu mod n, where L(x) = (x−1)/n. All modular reductions and the L-division run on one shared sequential restoring divider, so the stage is small and latency is deterministic.

## Interface
- `DATA_WIDTH`, 10: plaintext width; must be ≤ `N_WIDTH`.
- `N_WIDTH`, 10: modulus width; n² and ciphertext are `2*N_WIDTH` bits.
- `LAMBDA_WIDTH`, 10: private exponent width.
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `vld_in` in 1: request; accepted only when `busy`=0.
- `ciphertext` in `2*N_WIDTH`: c, as produced by `encrypt`.
- `lambda` in `LAMBDA_WIDTH`: private exponent.
- `mu` in `N_WIDTH`: private multiplier.
- `n` in `N_WIDTH`: public modulus.
- `plaintext` out `DATA_WIDTH`: recovered m, truncated to its low bits; held until the next `done`.
- `done` out 1: one-cycle pulse when `plaintext`/`err` are valid.
- `busy` out 1: high from the accept cycle through the `done` cycle.
- `err` out 1: qualifies `done`; high for n=0 or x=0.

## Operation
- Accept edge: `vld_in`=1 and `busy`=0. All inputs are registered, and n² is computed combinationally from the registered n.
- While `busy`=1, `vld_in` is ignored and the registered inputs do not change.
- States and transitions:
  - IDLE → EXP_SQ on accept. If n=0, IDLE → DONE with `err`=1 and `plaintext`=0.
  - EXP_SQ: acc ← acc·acc mod n², starting from acc=1. Exponent bits are scanned from MSB to LSB.
  - EXP_MUL: entered only when the current lambda bit is 1; acc ← acc·c mod n².
  - After the LSB, go to L_DIV with x=acc.
  - L_DIV: q ← (x−1) / n. If x=0, then q=0 and `err` is set.
  - MU_MUL: m ← q·mu mod n.
  - DONE: drives outputs for one cycle, then returns to IDLE.
- Products come from a combinational `2N×2N` multiply, zero-extended to a `4*N_WIDTH` dividend. The divisor is zero-extended to `2*N_WIDTH`.
- Inputs with c ≥ n² are legal; the first EXP_MUL reduces them.
- lambda=0 gives x=1, q=0, m=0, `err`=0.

## Timing
- Every divider operation takes D = 4·`N_WIDTH`+1 cycles: 1 issue cycle plus one quotient bit per cycle.
- `done` is high exactly T cycles after the accept edge, where T = 1 + (`LAMBDA_WIDTH` + popcount(lambda) + 2)·D. With defaults, D=41.
- For n=0, T=1.
- Reset values: `plaintext`=0, `done`=0, `busy`=0, `err`=0; FSM in IDLE; divider idle.
- Reset asserted mid-operation aborts the operation with no `done`. The first accept after release starts cleanly.
- `vld_in` high in the `done` cycle is not accepted, because `busy` is still 1. The earliest back-to-back accept is the cycle after `done`.
- `err` is valid only while `done`=1; otherwise it holds its last value.

## Configuration
- `DECRYPT_LZ_SKIP_EN` defined: leading zero bits of lambda are skipped, with no squaring of acc=1. In T, `LAMBDA_WIDTH` is replaced by bitlen(lambda). lambda=0 goes straight to L_DIV with x=1, so T = 1 + 2·D.
- `DECRYPT_LZ_SKIP_EN` undefined: every exponent bit is squared, giving the fixed-schedule T above.
- Results are identical in both builds.

## Structure
- `decrypt_pkg` holds:
  - the state enum (IDLE, EXP_SQ, EXP_MUL, L_DIV, MU_MUL, DONE);
  - a `div_cycles(N_WIDTH)` function;
  - the latency function used by the bench.
- One sub-module, `seq_divmod`: restoring divider with `start`/`done`, a `4*N_WIDTH` dividend and a `2*N_WIDTH` divisor, producing quotient and remainder. It is shared by all reduction and division steps.

## Test plan
- n=15, lambda=4, mu=4, c=83 → `plaintext`=7, `err`=0, `done` at 1+13·41=534 cycles (LZ_SKIP: 1+6·41=247).
- Same key, c=1 → `plaintext`=0, `err`=0.
- n=0, any c → `done` 1 cycle after accept, `err`=1, `plaintext`=0.
- c=0, n=15 → x=0, `err`=1, `plaintext`=0.
- `vld_in` held high through the first request with c=83 → only one `done`. A second request (c=1) is accepted on the cycle after `done` → 7, then 0.
- `rst_n` pulsed low at cycle 100 of a c=83 run → all outputs 0 and no `done`. The next request decrypts correctly.

Source files
------------

// File: rtl/decrypt_pkg.sv
// Shared types and helpers for the Paillier decryption stage.
// Build option: DECRYPT_LZ_SKIP_EN skips leading zero exponent bits.
package decrypt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXP_SQ,
        EXP_MUL,
        L_DIV,
        MU_MUL,
        DONE
    } state_e;

    // One issue cycle plus one quotient bit per cycle of a 4N-bit dividend.
    function automatic int div_cycles(input int nw);
        return 4 * nw + 1;
    endfunction

    // Accept-to-done distance; sq_bits is the number of squared exponent bits.
    function automatic int latency(
        input int nw,
        input int sq_bits,
        input int ones,
        input bit n_zero
    );
        if (n_zero)
            return 1;
        return 1 + (sq_bits + ones + 2) * div_cycles(nw);
    endfunction

endpackage

// File: rtl/decrypt_seq_divmod.sv
// Restoring divider shared by every reduction and the L-division.
// Result is presented combinationally on the cycle done is high.
module seq_divmod
    import decrypt_pkg::*;
#(
    parameter int N_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*N_WIDTH-1:0] dividend,
    input  logic [2*N_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [4*N_WIDTH-1:0] quotient,
    output logic [2*N_WIDTH-1:0] remainder
);

    localparam int NW2 = 2 * N_WIDTH;
    localparam int NW4 = 4 * N_WIDTH;
    localparam int CW  = $clog2(NW4);

    logic [NW2-1:0] rem_q, rem_d;
    logic [NW4-1:0] dvd_q, dvd_d;
    logic [NW2-1:0] dsr_q, dsr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;

    logic [NW2:0]   shifted;
    logic           ge;
    logic [NW2-1:0] rem_nx;
    logic [NW4-1:0] quo_nx;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_q, dvd_q[NW4-1]};
        ge      = shifted >= {1'b0, dsr_q};
        rem_nx  = ge ? (shifted[NW2-1:0] - dsr_q) : shifted[NW2-1:0];
        quo_nx  = {dvd_q[NW4-2:0], ge};
    end

    // Load operands on start, then walk all dividend bits.
    always_comb begin
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            rem_d = rem_nx;
            dvd_d = quo_nx;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0)
                busy_d = 1'b0;
        end else if (start) begin
            rem_d  = '0;
            dvd_d  = dividend;
            dsr_d  = divisor;
            cnt_d  = CW'(NW4 - 1);
            busy_d = 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == '0);
    assign quotient  = quo_nx;
    assign remainder = rem_nx;

endmodule

// File: rtl/decrypt.sv
// Paillier decryption: m = L(c^lambda mod n^2) * mu mod n on one divider.
// Build option: DECRYPT_LZ_SKIP_EN skips leading zero bits of lambda.
module decrypt
    import decrypt_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int N_WIDTH      = 10,
    parameter int LAMBDA_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld_in,
    input  logic [2*N_WIDTH-1:0]    ciphertext,
    input  logic [LAMBDA_WIDTH-1:0] lambda,
    input  logic [N_WIDTH-1:0]      mu,
    input  logic [N_WIDTH-1:0]      n,
    output logic [DATA_WIDTH-1:0]   plaintext,
    output logic                    done,
    output logic                    busy,
    output logic                    err
);

    localparam int NW2 = 2 * N_WIDTH;
    localparam int NW4 = 4 * N_WIDTH;
    localparam int LIW = (LAMBDA_WIDTH > 1) ? $clog2(LAMBDA_WIDTH) : 1;

    state_e                  state_q, state_d;
    logic [NW2-1:0]          c_q, c_d;
    logic [LAMBDA_WIDTH-1:0] lam_q, lam_d;
    logic [N_WIDTH-1:0]      mu_q, mu_d;
    logic [N_WIDTH-1:0]      n_q, n_d;
    logic [NW2-1:0]          acc_q, acc_d;
    logic [N_WIDTH-1:0]      q_q, q_d;
    logic [LIW-1:0]          idx_q, idx_d;
    logic                    xerr_q, xerr_d;
    logic [DATA_WIDTH-1:0]   plaintext_q, plaintext_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic [NW2-1:0] n_sq;
    logic [NW2-1:0] op_a, op_b;
    logic [NW4-1:0] prod;
    logic [NW2-1:0] x_m1;
    logic           div_start, div_busy, div_done;
    logic [NW4-1:0] div_dvd, div_quo;
    logic [NW2-1:0] div_dsr, div_rem;
    logic           unused_ok;

    assign n_sq      = NW2'(n_q) * NW2'(n_q);
    assign x_m1      = (acc_q == '0) ? '0 : acc_q - NW2'(1);
    assign unused_ok = ^div_quo[NW4-1:N_WIDTH];

`ifdef DECRYPT_LZ_SKIP_EN
    logic [LIW-1:0] lz_msb;

    // Highest set bit of the incoming exponent.
    always_comb begin
        lz_msb = '0;
        for (int i = 0; i < LAMBDA_WIDTH; i++)
            if (lambda[i])
                lz_msb = LIW'(i);
    end
`endif

    // Pick multiplier operands and divider inputs for the current step.
    always_comb begin
        op_a    = '0;
        op_b    = '0;
        div_dsr = n_sq;
        case (state_q)
            EXP_SQ: begin
                op_a = acc_q;
                op_b = acc_q;
            end
            EXP_MUL: begin
                op_a = acc_q;
                op_b = c_q;
            end
            L_DIV: div_dsr = NW2'(n_q);
            MU_MUL: begin
                op_a    = NW2'(q_q);
                op_b    = NW2'(mu_q);
                div_dsr = NW2'(n_q);
            end
            default: ;
        endcase
        prod      = NW4'(op_a) * NW4'(op_b);
        div_dvd   = (state_q == L_DIV) ? NW4'(x_m1) : prod;
        div_start = !div_busy &&
                    (state_q == EXP_SQ || state_q == EXP_MUL ||
                     state_q == L_DIV  || state_q == MU_MUL);
    end

    // Sequencer: accept, square-and-multiply, L-division, mu product.
    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        lam_d       = lam_q;
        mu_d        = mu_q;
        n_d         = n_q;
        acc_d       = acc_q;
        q_d         = q_q;
        idx_d       = idx_q;
        xerr_d      = xerr_q;
        plaintext_d = plaintext_q;
        err_d       = err_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        if (done_q)
            busy_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (vld_in && !busy_q) begin
                    c_d     = ciphertext;
                    lam_d   = lambda;
                    mu_d    = mu;
                    n_d     = n;
                    acc_d   = NW2'(1);
                    q_d     = '0;
                    xerr_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = LIW'(LAMBDA_WIDTH - 1);
                    state_d = EXP_SQ;
`ifdef DECRYPT_LZ_SKIP_EN
                    idx_d = lz_msb;
                    if (lambda == '0)
                        state_d = L_DIV;
`else
`endif
                    if (n == '0) begin
                        xerr_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            EXP_SQ: begin
                if (div_done) begin
                    acc_d = div_rem;
                    if (lam_q[idx_q])
                        state_d = EXP_MUL;
                    else if (idx_q == '0)
                        state_d = L_DIV;
                    else
                        idx_d = idx_q - 1'b1;
                end
            end
            EXP_MUL: begin
                if (div_done) begin
                    acc_d = div_rem;
                    if (idx_q == '0) begin
                        state_d = L_DIV;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = EXP_SQ;
                    end
                end
            end
            L_DIV: begin
                if (div_done) begin
                    q_d     = (acc_q == '0) ? '0 : div_quo[N_WIDTH-1:0];
                    xerr_d  = (acc_q == '0);
                    state_d = MU_MUL;
                end
            end
            MU_MUL: begin
                if (div_done) begin
                    q_d     = div_rem[N_WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d      = 1'b1;
                err_d       = xerr_q;
                plaintext_d = xerr_q ? '0 : q_q[DATA_WIDTH-1:0];
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c_q         <= '0;
            lam_q       <= '0;
            mu_q        <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            idx_q       <= '0;
            xerr_q      <= 1'b0;
            plaintext_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            lam_q       <= lam_d;
            mu_q        <= mu_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            idx_q       <= idx_d;
            xerr_q      <= xerr_d;
            plaintext_q <= plaintext_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    seq_divmod #(
        .N_WIDTH(N_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dvd),
        .divisor  (div_dsr),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    assign plaintext = plaintext_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
